// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - registered ALU control decoder with valid/ready output, multiply sequencing and op counter (optional multiply: ALU_CTRL_MULT_EN)
module alu_ctrl_pipe #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funct,
    input  logic             inValid,
    output logic             inReady,
    output logic             outValid,
    input  logic             outReady,
    output logic [3:0]       aluOpSig,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] opCount
);

    // Reject a multiply length that cannot be sequenced
    generate
        if (MULT_CYCLES < 1) begin : g_bad_mult_cycles
            $error("alu_ctrl_pipe: MULT_CYCLES must be at least 1");
        end
    endgenerate

    // ALU operation select encodings
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_BAD = 4'b1111;

    // R-type function codes understood by the decoder
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_MULT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0] dec_op;
    logic       dec_ill;
    logic       accept;

`ifdef ALU_CTRL_MULT_EN
    // Counter only needs to hold MULT_CYCLES-1
    localparam int MC_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MULT_CYCLES - 1);

    logic            dec_mult;
    logic [MC_W-1:0] mult_cnt;
`endif

    // Decode the request; aluOp[1] selects R-type decoding of funct
    always_comb begin
        dec_op  = OP_BAD;
        dec_ill = 1'b0;
`ifdef ALU_CTRL_MULT_EN
        dec_mult = 1'b0;
`endif
        if (aluOp[1]) begin
            case (funct)
                FN_ADD: dec_op = OP_ADD;
                FN_SUB: dec_op = OP_SUB;
                FN_AND: dec_op = OP_AND;
                FN_OR:  dec_op = OP_OR;
                FN_SLT: dec_op = OP_SLT;
                FN_MULT: begin
`ifdef ALU_CTRL_MULT_EN
                    dec_op   = OP_MUL;
                    dec_mult = 1'b1;
`else
                    // Without the multiplier this code is unsupported
                    dec_op  = OP_BAD;
                    dec_ill = 1'b1;
`endif
                end
                default: begin
                    dec_op  = OP_BAD;
                    dec_ill = 1'b1;
                end
            endcase
        end else if (aluOp[0]) begin
            dec_op = OP_SUB;
        end else begin
            dec_op = OP_ADD;
        end
    end

    assign accept = inValid && inReady;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_CTRL_MULT_EN
                    state_next = dec_mult ? S_MULT : S_VALID;
`else
                    state_next = S_VALID;
`endif
                end
            end
`ifdef ALU_CTRL_MULT_EN
            S_MULT: begin
                if (mult_cnt == '0) begin
                    state_next = S_VALID;
                end
            end
`endif
            S_VALID: begin
                if (outReady) begin
                    if (inValid) begin
`ifdef ALU_CTRL_MULT_EN
                        state_next = dec_mult ? S_MULT : S_VALID;
`else
                        state_next = S_VALID;
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs derived from the current state
    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE:  inReady = 1'b1;
            // A consumer taking the output frees the slot in the same cycle
            S_VALID: begin
                outValid = 1'b1;
                inReady  = outReady;
            end
`ifdef ALU_CTRL_MULT_EN
            S_MULT:  busy = 1'b1;
`endif
            default: inReady = 1'b0;
        endcase
    end

    // Result register: loaded only on accept so a stalled output holds steady
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluOpSig <= 4'b0000;
            illegal  <= 1'b0;
        end else if (accept) begin
            aluOpSig <= dec_op;
            illegal  <= dec_ill;
        end
    end

    // Issued-operation counter; illegal requests count too, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opCount <= '0;
        end else if (accept) begin
            opCount <= opCount + 1'b1;
        end
    end

`ifdef ALU_CTRL_MULT_EN
    // Multiply sequence counter: loaded on a multiply accept, counts down while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_cnt <= '0;
        end else if (accept && dec_mult) begin
            mult_cnt <= MC_LOAD;
        end else if (state == S_MULT && mult_cnt != '0) begin
            mult_cnt <= mult_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb/tb_alu_ctrl_pipe.sv - self-checking bench for alu_ctrl_pipe against a transaction-level reference model
module tb_alu_ctrl_pipe;

    localparam int MC = 4;
    localparam int CW = 4;
`ifdef ALU_CTRL_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    aluOp;
    logic [5:0]    funct;
    logic          inValid;
    logic          inReady;
    logic          outValid;
    logic          outReady;
    logic [3:0]    aluOpSig;
    logic          illegal;
    logic          busy;
    logic [CW-1:0] opCount;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending output, remaining multiply cycles, accept count
    bit       m_valid;
    bit [3:0] m_op;
    bit       m_ill;
    int       m_busy_left;
    int       m_cnt;

    alu_ctrl_pipe #(.MULT_CYCLES(MC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .aluOp(aluOp), .funct(funct),
        .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
        .aluOpSig(aluOpSig), .illegal(illegal), .busy(busy), .opCount(opCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {is_mult, illegal, sig} for a request
    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {2'b00, 4'h2};
        if (op == 2'b01) return {2'b00, 4'h6};
        if (f == 6'd32) return {2'b00, 4'h2};
        if (f == 6'd34) return {2'b00, 4'h6};
        if (f == 6'd36) return {2'b00, 4'h0};
        if (f == 6'd37) return {2'b00, 4'h1};
        if (f == 6'd42) return {2'b00, 4'h7};
        if (f == 6'd24 && MULT_EN) return {2'b10, 4'h8};
        return {2'b01, 4'hF};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 4'h0; m_ill = 0; m_busy_left = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_outValid"}, 32'(outValid), 32'(m_valid));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy_left > 0));
        chk({tag, "_aluOpSig"}, 32'(aluOpSig), 32'(m_op));
        chk({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
        chk({tag, "_opCount"}, 32'(opCount), 32'(m_cnt));
    endtask

    // One clock: check ready, advance model on the edge, check registered outputs
    task automatic tick(input string tag);
        bit       ready;
        bit       acc;
        bit [5:0] d;
        #1;
        ready = (m_busy_left == 0) && (!m_valid || outReady);
        chk({tag, "_inReady"}, 32'(inReady), 32'(ready));
        acc = ready && inValid;
        d = ref_decode(aluOp, funct);
        @(posedge clk);
        if (acc) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_op  = d[3:0];
            m_ill = d[4];
            if (d[5]) begin
                m_busy_left = MC;
                m_valid = 0;
            end else begin
                m_valid = 1;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_valid = 1;
        end else if (m_valid && outReady) begin
            m_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic r);
        inValid = v; aluOp = op; funct = f; outReady = r;
    endtask

    initial begin
        logic [5:0] rtype [5];
        logic [5:0] pool [8];
        logic [3:0] held;
        rtype = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        pool  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd7, 6'd0};

        // Reset state
        reset = 1'b1;
        drive(0, 2'b00, 6'd0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inReady", 32'(inReady), 32'h1);
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single add pulse
        drive(1, 2'b00, 6'h3f, 1);
        tick("add");
        chk("add_sig_const", 32'(aluOpSig), 32'h2);
        chk("add_cnt_const", 32'(opCount), 32'h1);
        drive(0, 2'b00, 6'h00, 1);
        tick("add_drain");
        chk("add_drain_valid_const", 32'(outValid), 32'h0);

        // Back-to-back R-type operations
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b10, rtype[i], 1);
            tick("rtype");
        end
        drive(0, 2'b10, 6'd0, 1);
        tick("rtype_drain");

        // Backpressure with a pending subtract
        drive(1, 2'b01, 6'd0, 1);
        tick("bp_sub");
        held = aluOpSig;
        chk("bp_sub_const", 32'(held), 32'h6);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 6'd37, 0);
            tick("bp_hold");
        end
        chk("bp_held_const", 32'(aluOpSig), 32'h6);
        drive(1, 2'b10, 6'd37, 1);
        tick("bp_release");
        chk("bp_release_const", 32'(aluOpSig), 32'h1);
        drive(0, 2'b00, 6'd0, 1);
        tick("bp_drain");

        // Multiply (or illegal without the multiplier)
        drive(1, 2'b11, 6'd24, 1);
        tick("mul_acc");
        drive(0, 2'b00, 6'd0, 1);
        for (int i = 0; i < MC + 2; i++) tick("mul_seq");

        // Unsupported funct
        drive(1, 2'b10, 6'd7, 1);
        tick("ill");
        chk("ill_sig_const", 32'(aluOpSig), 32'hF);
        chk("ill_flag_const", 32'(illegal), 32'h1);
        drive(0, 2'b00, 6'd0, 1);
        tick("ill_drain");

        // Asynchronous reset in the middle of an operation
        drive(1, 2'b10, 6'd24, 1);
        tick("rst_mid_acc");
        drive(0, 2'b00, 6'd0, 0);
        tick("rst_mid_run");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_inReady", 32'(inReady), 32'h1);
        check_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Counter wrap: 17 accepts on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive(1, 2'b00, 6'd0, 1);
            tick("wrap");
        end
        chk("wrap_cnt_const", 32'(opCount), 32'h1);
        drive(0, 2'b00, 6'd0, 1);
        tick("wrap_drain");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 7)],
                  1'($urandom_range(0, 2) != 0));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, handshaked successor to the combinational ALU control decoder. It accepts `aluOp` from main control plus the R-type `funct` field and produces the 4-bit ALU operation select behind a valid/ready output stage. It also sequences a multi-cycle multiply, flags unsupported funct codes and counts issued operations. It sits between the decode stage and the ALU/multiplier in the multicycle datapath.

## Interface
- `MULT_CYCLES`, default 4: cycles spent in the multiply sequence; legal range ≥1.
- `CNT_W`, default 16: width of the issued-operation counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `aluOp`  in  2  00 = add (load/store), 01 = subtract (branch), 1x = R-type, decode `funct`.
- `funct`  in  6  R-type function field.
- `inValid`  in  1  the request on `aluOp`/`funct` is valid.
- `inReady`  out  1  the block accepts a request this cycle.
- `outValid`  out  1  `aluOpSig`/`illegal` are valid.
- `outReady`  in  1  the consumer takes the output this cycle.
- `aluOpSig`  out  4  ALU operation select.
- `illegal`  out  1  the output corresponds to an unsupported funct.
- `busy`  out  1  the multiply sequence is in progress.
- `opCount`  out  CNT_W  number of accepted requests; wraps modulo 2^CNT_W.

## Operation
- Decode with `aluOp[1]` taking priority:
  - 00 → 0010.
  - 01 → 0110.
  - 1x with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - 1x with funct 011000 → 1000 (multiply, see Configuration).
  - Any other funct → 1111 with `illegal`=1.
- Accept condition: `inValid && inReady`.
- FSM states:
  - IDLE: `inReady`=1, `outValid`=0. On accept of a multiply → MULT with counter = MULT_CYCLES-1. On accept of any other request → VALID.
  - MULT: `inReady`=0, `outValid`=0, `busy`=1, `aluOpSig`=1000. The counter decrements each cycle. At counter 0 → VALID.
  - VALID: `outValid`=1 and `inReady`=`outReady`.
    - `outReady && inValid`: load the new decode; go to VALID, or to MULT for a multiply.
    - `outReady && !inValid`: → IDLE.
    - `!outReady`: hold all outputs stable.
- `aluOpSig` and `illegal` are registered on accept and change only on accept.
- `opCount` increments by 1 on every accept, including illegal requests.
- `aluOp` and `funct` are ignored when no accept occurs.

## Timing
- Reset values:
  - state IDLE, `inReady`=1, `outValid`=0.
  - `aluOpSig`=0000, `illegal`=0, `busy`=0.
  - counter 0, `opCount`=0.
- Latency from accept to `outValid`:
  - single-cycle operations: 1 cycle.
  - multiply: MULT_CYCLES+1 cycles.
- Throughput: one single-cycle operation per cycle with `outReady` held at 1, with no bubbles.
- Reset asserted in MULT or VALID aborts the operation immediately. Outputs return to their reset values asynchronously, and the pending output is discarded.
- `outReady` while `outValid`=0 has no effect.
- `opCount` at all-ones wraps to 0 on the next accept.

## Configuration
- `ALU_CTRL_MULT_EN` defined: funct 011000 under `aluOp`=1x enters MULT, then emits 1000 with `illegal`=0. The MULT state and counter are present.
- Not defined: funct 011000 decodes as illegal (1111, `illegal`=1, latency 1). The MULT state and counter are not built, and `busy` is tied to 0.

## Test plan
- Reset, then `aluOp`=00 with `inValid` pulsed one cycle and `outReady`=1 → next cycle `outValid`=1, `aluOpSig`=0010, `opCount`=1; following cycle `outValid`=0.
- `aluOp`=10 with funct 100000, 100010, 100100, 100101, 101010 on back-to-back cycles, `outReady`=1 → `aluOpSig` 0010, 0110, 0000, 0001, 0111 on consecutive cycles, `inReady` held at 1.
- Backpressure: emit 0110, then hold `outReady`=0 for 3 cycles with `inValid`=1 → `inReady`=0, `aluOpSig` stays 0110, `opCount` unchanged; on release, the next op appears 1 cycle later.
- With `ALU_CTRL_MULT_EN` and MULT_CYCLES=4: funct 011000 → `busy`=1 for 4 cycles, `inReady`=0, then `outValid`=1 with `aluOpSig`=1000. Without the macro: 1111 and `illegal`=1 after 1 cycle.
- `aluOp`=10 with funct 000111 → `aluOpSig`=1111, `illegal`=1, `opCount` increments.
- Assert `reset` mid-MULT and with CNT_W=2 drive 5 accepts → outputs return to reset values immediately; `opCount` reads 1 after the 5 accepts (wrap).
